// File: rtl/drone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : drone_pkg
// Description : Shared constants for the flight-control datapath: PID engine
//               state encoding, default datapath widths and channel indices.
// Revision    : 1.0 - initial release
// ============================================================================
package drone_pkg;

  // PID engine sequencer states
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ERR  = 3'd1;
  localparam logic [2:0] S_P    = 3'd2;
  localparam logic [2:0] S_I    = 3'd3;
  localparam logic [2:0] S_D    = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  // Default datapath widths
  localparam int DW_DEF = 16;  // signed target/measurement/output width
  localparam int KW_DEF = 8;   // unsigned gain width
  localparam int AW_DEF = 40;  // signed accumulator width

  // Channel assignment
  localparam int CH_PITCH  = 0;
  localparam int CH_ROLL   = 1;
  localparam int CH_YAW    = 2;
  localparam int CH_HEIGHT = 3;

endpackage
`default_nettype wire

// File: rtl/sat_clamp.sv
`default_nettype none
// ============================================================================
// Module      : sat_clamp
// Description : Combinational signed clamp. Limits a signed IW-bit value to
//               [LO, HI] and narrows it to OW bits; hit flags a clamp event.
// Revision    : 1.0 - initial release
// Ports       : raw   in  IW  signed value to be limited
//               value out OW  signed limited value
//               hit   out 1   raw was outside [LO, HI]
// ============================================================================
module sat_clamp #(
  parameter int     IW = 17,
  parameter int     OW = 16,
  parameter longint HI = 32767,
  parameter longint LO = -32768
) (
  input  logic signed [IW-1:0] raw,
  output logic signed [OW-1:0] value,
  output logic                 hit
);

  localparam logic signed [IW-1:0] c_hi = IW'(HI);
  localparam logic signed [IW-1:0] c_lo = IW'(LO);

  always_comb begin
    value = raw[OW-1:0];
    hit   = 1'b0;
    if (raw > c_hi) begin
      value = c_hi[OW-1:0];
      hit   = 1'b1;
    end else if (raw < c_lo) begin
      value = c_lo[OW-1:0];
      hit   = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pid_multi_axis.sv
`default_nettype none
// ============================================================================
// Module      : pid_multi_axis
// Description : Time-multiplexed PID engine for N_CH channels sharing one
//               signed multiplier. Per channel: ERR -> P -> I -> D -> OUT,
//               with saturating error, anti-windup integrator and output clamp.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n      clock, async active-low reset
//               start           one-cycle run request (IDLE only)
//               arm             0 = zero outputs and clear history for the run
//               clear_i         zero integrators/previous errors (IDLE only)
//               tgt, meas       packed signed targets / measurements
//               kp, ki, kd      packed unsigned gains
//               busy            run in progress
//               done            one-cycle completion pulse
//               corr            packed signed corrections, held between runs
//               sat             per-channel output-clamp flags
// ============================================================================
module pid_multi_axis
  import drone_pkg::*;
#(
  parameter int     N_CH    = 3,
  parameter int     DW      = DW_DEF,
  parameter int     KW      = KW_DEF,
  parameter int     AW      = AW_DEF,
  parameter int     SHIFT   = 4,
  parameter longint I_LIM   = 100000,
  parameter longint OUT_LIM = 30000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               arm,
  input  logic               clear_i,
  input  logic [N_CH*DW-1:0] tgt,
  input  logic [N_CH*DW-1:0] meas,
  input  logic [N_CH*KW-1:0] kp,
  input  logic [N_CH*KW-1:0] ki,
  input  logic [N_CH*KW-1:0] kd,
  output logic               busy,
  output logic               done,
  output logic [N_CH*DW-1:0] corr,
  output logic [N_CH-1:0]    sat
);

  localparam int            CW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] c_last = CW'(N_CH - 1);

  logic [2:0]           r_state;
  logic [CW-1:0]        r_ch;
  logic                 r_arm;
  logic signed [DW-1:0] r_tgt    [N_CH];
  logic signed [DW-1:0] r_meas   [N_CH];
  logic [KW-1:0]        r_kp     [N_CH];
  logic [KW-1:0]        r_ki     [N_CH];
  logic [KW-1:0]        r_kd     [N_CH];
  logic signed [AW-1:0] r_iacc   [N_CH];
  logic signed [DW-1:0] r_prev   [N_CH];
  logic signed [DW-1:0] r_corr_w [N_CH];
  logic [N_CH-1:0]      r_sat_w;
  logic signed [DW-1:0] r_e;
  logic signed [DW:0]   r_d;
  logic signed [AW-1:0] r_acc;

  logic signed [DW:0]   w_diff;
  logic signed [DW-1:0] w_e;
  logic signed [AW:0]   w_isum;
  logic signed [AW-1:0] w_inew;
  logic signed [DW+1:0] w_ddiff;
  logic signed [DW:0]   w_d;
  logic [KW-1:0]        w_gain;
  logic signed [AW-1:0] w_opnd;
  logic signed [AW-1:0] w_prod;
  logic signed [AW-1:0] w_shr;
  logic signed [DW-1:0] w_out;
  logic                 w_out_hit;
  logic signed [DW-1:0] w_corr_new;
  logic                 w_sat_new;
  logic                 w_e_hit, w_i_hit, w_d_hit;
  logic                 w_unused_hits;

  // Error is formed one bit wider so the subtraction itself cannot wrap
  assign w_diff  = (DW+1)'(r_tgt[r_ch]) - (DW+1)'(r_meas[r_ch]);
  assign w_isum  = (AW+1)'(r_iacc[r_ch]) + (AW+1)'(w_e);
  assign w_ddiff = (DW+2)'(w_e) - (DW+2)'(r_prev[r_ch]);

  sat_clamp #(
    .IW(DW+1), .OW(DW),
    .HI((64'sd1 <<< (DW-1)) - 64'sd1), .LO(-(64'sd1 <<< (DW-1)))
  ) u_err_sat (.raw(w_diff), .value(w_e), .hit(w_e_hit));

  sat_clamp #(
    .IW(AW+1), .OW(AW), .HI(I_LIM), .LO(-I_LIM)
  ) u_int_sat (.raw(w_isum), .value(w_inew), .hit(w_i_hit));

  sat_clamp #(
    .IW(DW+2), .OW(DW+1),
    .HI((64'sd1 <<< DW) - 64'sd1), .LO(-(64'sd1 <<< DW))
  ) u_der_sat (.raw(w_ddiff), .value(w_d), .hit(w_d_hit));

  // Only the output clamp event is reported; the others just limit values
  assign w_unused_hits = w_e_hit | w_i_hit | w_d_hit;

  // Shared multiplier: operand pair selected by the current term state.
  // The integrator operand is the value already updated in ERR.
  always_comb begin
    w_gain = r_kp[r_ch];
    w_opnd = AW'(r_e);
    case (r_state)
      S_I: begin
        w_gain = r_ki[r_ch];
        w_opnd = r_iacc[r_ch];
      end
      S_D: begin
        w_gain = r_kd[r_ch];
        w_opnd = AW'(r_d);
      end
      default: ;
    endcase
  end

  assign w_prod = AW'($signed({1'b0, w_gain})) * w_opnd;
  assign w_shr  = r_acc >>> SHIFT;

  sat_clamp #(
    .IW(AW), .OW(DW), .HI(OUT_LIM), .LO(-OUT_LIM)
  ) u_out_sat (.raw(w_shr), .value(w_out), .hit(w_out_hit));

  assign w_corr_new = r_arm ? w_out : '0;
  assign w_sat_new  = r_arm & w_out_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_arm   <= 1'b0;
      r_sat_w <= '0;
      r_e     <= '0;
      r_d     <= '0;
      r_acc   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      corr    <= '0;
      sat     <= '0;
      for (int c = 0; c < N_CH; c++) begin
        r_tgt[c]    <= '0;
        r_meas[c]   <= '0;
        r_kp[c]     <= '0;
        r_ki[c]     <= '0;
        r_kd[c]     <= '0;
        r_iacc[c]   <= '0;
        r_prev[c]   <= '0;
        r_corr_w[c] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear_i) begin
            for (int c = 0; c < N_CH; c++) begin
              r_iacc[c] <= '0;
              r_prev[c] <= '0;
            end
          end
          if (start) begin
            for (int c = 0; c < N_CH; c++) begin
              r_tgt[c]  <= tgt[c*DW +: DW];
              r_meas[c] <= meas[c*DW +: DW];
              r_kp[c]   <= kp[c*KW +: KW];
              r_ki[c]   <= ki[c*KW +: KW];
              r_kd[c]   <= kd[c*KW +: KW];
            end
            r_arm   <= arm;
            r_ch    <= '0;
            busy    <= 1'b1;
            r_state <= S_ERR;
          end
        end
        S_ERR: begin
          r_e          <= w_e;
          r_d          <= w_d;
          r_iacc[r_ch] <= r_arm ? w_inew : '0;
          r_state      <= S_P;
        end
        S_P: begin
          r_acc   <= w_prod;
          r_state <= S_I;
        end
        S_I: begin
          r_acc   <= r_acc + w_prod;
          r_state <= S_D;
        end
        S_D: begin
          r_acc   <= r_acc + w_prod;
          r_state <= S_OUT;
        end
        S_OUT: begin
          r_corr_w[r_ch] <= w_corr_new;
          r_sat_w[r_ch]  <= w_sat_new;
          r_prev[r_ch]   <= r_arm ? r_e : '0;
          if (r_ch == c_last) begin
            // Publish all channels together so corr only changes with done
            for (int c = 0; c < N_CH; c++) begin
              if (CW'(c) == r_ch) begin
                corr[c*DW +: DW] <= w_corr_new;
                sat[c]           <= w_sat_new;
              end else begin
                corr[c*DW +: DW] <= r_corr_w[c];
                sat[c]           <= r_sat_w[c];
              end
            end
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ch    <= r_ch + CW'(1);
            r_state <= S_ERR;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pid_multi_axis.sv
`default_nettype none
// ============================================================================
// Module      : tb_pid_multi_axis
// Description : Self-checking bench for pid_multi_axis. A behavioural PID model
//               predicts each run's corrections; predictions are queued at
//               launch and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pid_multi_axis;

  localparam int N    = 3;
  localparam int DW   = 16;
  localparam int KW   = 8;
  localparam int SH   = 4;
  localparam int ILIM = 25;
  localparam int OLIM = 30000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           arm = 1'b0;
  logic           clear_i = 1'b0;
  logic [N*DW-1:0] tgt = '0;
  logic [N*DW-1:0] meas = '0;
  logic [N*KW-1:0] kp = '0;
  logic [N*KW-1:0] ki = '0;
  logic [N*KW-1:0] kd = '0;
  logic           busy;
  logic           done;
  logic [N*DW-1:0] corr;
  logic [N-1:0]   sat;

  always #5 clk = ~clk;

  pid_multi_axis #(
    .N_CH(N), .DW(DW), .KW(KW), .AW(40), .SHIFT(SH),
    .I_LIM(ILIM), .OUT_LIM(OLIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .arm(arm), .clear_i(clear_i),
    .tgt(tgt), .meas(meas), .kp(kp), .ki(ki), .kd(kd),
    .busy(busy), .done(done), .corr(corr), .sat(sat)
  );

  typedef struct packed {
    logic [N*DW-1:0] corr;
    logic [N-1:0]    sat;
  } exp_t;

  exp_t   sb[$];
  int     n_vec = 0;
  int     n_err = 0;
  longint m_iacc[N];
  longint m_prev[N];
  int     bt[N], bm[N], bp[N], bi[N], bd[N];

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint lclamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Behavioural reference for one run; updates the model's channel history
  function automatic exp_t model(input logic a, input logic clr);
    exp_t   r;
    longint e, d, acc, rr;
    r = '0;
    if (clr) begin
      for (int c = 0; c < N; c++) begin
        m_iacc[c] = 0;
        m_prev[c] = 0;
      end
    end
    for (int c = 0; c < N; c++) begin
      e = lclamp(longint'(bt[c]) - longint'(bm[c]), -32768, 32767);
      if (!a) begin
        m_iacc[c] = 0;
        m_prev[c] = 0;
      end else begin
        m_iacc[c] = lclamp(m_iacc[c] + e, -ILIM, ILIM);
        d   = lclamp(e - m_prev[c], -65536, 65535);
        acc = longint'(bp[c]) * e + longint'(bi[c]) * m_iacc[c] + longint'(bd[c]) * d;
        rr  = acc >>> SH;
        if (rr > OLIM) begin
          rr = OLIM;
          r.sat[c] = 1'b1;
        end else if (rr < -OLIM) begin
          rr = -OLIM;
          r.sat[c] = 1'b1;
        end
        r.corr[c*DW +: DW] = rr[DW-1:0];
        m_prev[c] = e;
      end
    end
    return r;
  endfunction

  task automatic zero_all();
    for (int c = 0; c < N; c++) begin
      bt[c] = 0; bm[c] = 0; bp[c] = 0; bi[c] = 0; bd[c] = 0;
    end
  endtask

  task automatic launch(input logic a, input logic clr);
    sb.push_back(model(a, clr));
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      tgt[c*DW +: DW]  = bt[c][DW-1:0];
      meas[c*DW +: DW] = bm[c][DW-1:0];
      kp[c*KW +: KW]   = bp[c][KW-1:0];
      ki[c*KW +: KW]   = bi[c][KW-1:0];
      kd[c*KW +: KW]   = bd[c][KW-1:0];
    end
    arm = a; clear_i = clr; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; clear_i = 1'b0;
    // Inputs wander after acceptance; the run must use the latched copy
    arm  = ~a;
    tgt  = 48'({$urandom(), $urandom()});
    meas = 48'({$urandom(), $urandom()});
    kp   = 24'($urandom());
    ki   = 24'($urandom());
    kd   = 24'($urandom());
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input int inject);
    int   n;
    exp_t ex;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == inject);
    end
    start = 1'b0;
    if (!done) begin
      check("done_seen", 0, 1);
    end else begin
      check("latency", n + 1, 16);
      if (sb.size() == 0) begin
        check("scoreboard_nonempty", 0, 1);
      end else begin
        ex = sb.pop_front();
        for (int c = 0; c < N; c++)
          check($sformatf("corr%0d", c), $signed(corr[c*DW +: DW]), $signed(ex.corr[c*DW +: DW]));
        check("sat", sat, ex.sat);
      end
    end
    @(posedge clk);
    #1;
    check("done_pulse_width", done, 0);
  endtask

  task automatic no_done(input int cycles);
    int cnt;
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("spurious_done", cnt, 0);
  endtask

  task automatic corr_is(input int ch, input int v);
    check($sformatf("corr%0d_value", ch), $signed(corr[ch*DW +: DW]), v);
  endtask

  task automatic cfg_prop();
    zero_all();
    bt[0] = 100; bm[0] = 40; bp[0] = 16;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < N; c++) begin
      m_iacc[c] = 0;
      m_prev[c] = 0;
    end
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_corr", corr, 0);
    check("rst_sat", sat, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Proportional only
    cfg_prop();
    launch(1'b1, 1'b1); wait_done(0); corr_is(0, 60);

    // Integrator with anti-windup
    zero_all();
    bt[1] = 10; bi[1] = 16;
    launch(1'b1, 1'b1); wait_done(0); corr_is(1, 10);
    launch(1'b1, 1'b0); wait_done(0); corr_is(1, 20);
    launch(1'b1, 1'b0); wait_done(0); corr_is(1, 25);
    bt[1] = -10;
    launch(1'b1, 1'b0); wait_done(0); corr_is(1, 15);

    // Derivative and clear
    zero_all();
    bt[2] = 10; bd[2] = 16;
    launch(1'b1, 1'b1); wait_done(0); corr_is(2, 10);
    bt[2] = 30;
    launch(1'b1, 1'b0); wait_done(0); corr_is(2, 20);
    launch(1'b1, 1'b1); wait_done(0); corr_is(2, 30);

    // Error and output saturation
    zero_all();
    bt[0] = 32767; bm[0] = -32768; bp[0] = 255;
    launch(1'b1, 1'b1); wait_done(0); corr_is(0, 30000);
    bt[0] = -32768; bm[0] = 32767;
    launch(1'b1, 1'b0); wait_done(0); corr_is(0, -30000);

    // Mixed random runs
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < N; c++) begin
        if (r < 2) begin
          bt[c] = int'($urandom_range(0, 600)) - 300;
          bm[c] = int'($urandom_range(0, 600)) - 300;
        end else begin
          bt[c] = int'($urandom_range(0, 65535)) - 32768;
          bm[c] = int'($urandom_range(0, 65535)) - 32768;
        end
        bp[c] = int'($urandom_range(0, 255));
        bi[c] = int'($urandom_range(0, 255));
        bd[c] = int'($urandom_range(0, 255));
      end
      launch(1'b1, 1'b0); wait_done(0);
    end

    // Start while busy is ignored
    cfg_prop();
    launch(1'b1, 1'b1); wait_done(3); no_done(20);

    // Disarmed run zeroes outputs and history
    for (int c = 0; c < N; c++) begin
      bt[c] = 200 + c; bm[c] = -100; bp[c] = 40; bi[c] = 30; bd[c] = 20;
    end
    launch(1'b1, 1'b0); wait_done(0);
    launch(1'b0, 1'b0); wait_done(0);
    check("disarmed_corr", corr, 0);
    zero_all();
    bt[1] = 10; bi[1] = 16; bt[2] = 10; bd[2] = 16;
    launch(1'b1, 1'b0); wait_done(0); corr_is(1, 10); corr_is(2, 10);

    // Reset in the middle of a run
    cfg_prop();
    launch(1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_corr", corr, 0);
    check("midrst_sat", sat, 0);
    sb.delete();
    for (int c = 0; c < N; c++) begin
      m_iacc[c] = 0;
      m_prev[c] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    no_done(20);
    launch(1'b1, 1'b0); wait_done(0); corr_is(0, 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
